// File: rtl/ram_word_adapter.sv
// rtl/ram_word_adapter.sv - byte-serial RAM port-A sequencer for CPU byte/halfword/word accesses
//
// Takes one load/store request from the CPU load/store unit and runs it as
// 1, 2 or 4 byte-wide cycles on RAM port A, most significant byte first.
// Loads are assembled big-endian and zero-extended; completion is a
// one-cycle ack.
//
// Build option: define ALIGN_CHECK_EN to reject misaligned halfword/word
// requests with a one-cycle err+ack and no RAM access. Without it, err is
// tied low and misaligned requests run byte-serially from addr.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, we, size       request strobe (sampled in IDLE), store flag, size code
//   addr, wdata         MS-byte address, right-aligned store data
//   rdata, ack          load result (valid with ack), completion pulse
//   busy, err           in-flight flag, misalignment pulse
//   ram_addr, ram_din   RAM port-A address and write byte
//   ram_we              RAM port-A write enable
//   ram_dout, ram_busy  RAM port-A read byte and its not-valid flag
module ram_word_adapter #(
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ack,
    output logic                     busy,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [7:0]               ram_din,
    output logic                     ram_we,
    input  logic [7:0]               ram_dout,
    input  logic                     ram_busy
);

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [1:0]               last_q, last_d;    // index of the final byte (N-1)
    logic [1:0]               k_q, k_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              asm_q, asm_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]               ram_din_q, ram_din_d;
    logic                     ram_we_q, ram_we_d;
    logic                     ack_q, ack_d;
    logic                     busy_q, busy_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               k_inc;
`ifdef ALIGN_CHECK_EN
    logic                     err_q, err_d;
`endif

    function automatic logic [1:0] last_index(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;    // word, and reserved code treated as word
        endcase
    endfunction

    // Byte idx of the right-aligned store word (0 = least significant).
    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        last_d     = last_q;
        k_d        = k_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = 8'h00;
        ram_we_d   = 1'b0;
        ack_d      = 1'b0;
        rdata_d    = 32'h0;
        k_inc      = k_q + 2'd1;
`ifdef ALIGN_CHECK_EN
        err_d      = 1'b0;
`endif
        // Outputs are registered, so each branch computes what the next
        // state will present on the RAM port.
        case (state_q)
            IDLE: begin
                if (req) begin
                    base_d  = addr;
                    last_d  = last_index(size);
                    wdata_d = wdata;
                    asm_d   = 32'h0;
                    k_d     = 2'd0;
`ifdef ALIGN_CHECK_EN
                    if ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00)) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else
`endif
                    if (we) begin
                        state_d    = WRITE;
                        ram_addr_d = addr;
                        ram_we_d   = 1'b1;
                        ram_din_d  = sel_byte(wdata, last_index(size));
                    end else begin
                        state_d    = ISSUE;
                        ram_addr_d = addr;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // The read byte belongs to the address held since ISSUE; wait
                // here as long as the RAM flags it invalid.
                if (!ram_busy) begin
                    asm_d = {asm_q[23:0], ram_dout};
                    k_d   = k_inc;
                    if (k_q == last_q) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        rdata_d = {asm_q[23:0], ram_dout};
                    end else begin
                        state_d    = ISSUE;
                        ram_addr_d = base_q + ADDRESS_WIDTH'(k_inc);
                    end
                end
            end
            WRITE: begin
                k_d = k_inc;
                if (k_q == last_q) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else begin
                    ram_addr_d = base_q + ADDRESS_WIDTH'(k_inc);
                    ram_we_d   = 1'b1;
                    ram_din_d  = sel_byte(wdata_q, last_q - k_inc);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            last_q     <= 2'd0;
            k_q        <= 2'd0;
            wdata_q    <= 32'h0;
            asm_q      <= 32'h0;
            ram_addr_q <= '0;
            ram_din_q  <= 8'h00;
            ram_we_q   <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 32'h0;
`ifdef ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            last_q     <= last_d;
            k_q        <= k_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
`ifdef ALIGN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
`ifdef ALIGN_CHECK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: doc/ram_word_adapter.md
# ram_word_adapter

Sequencer between the CPU load/store unit and the byte-wide data port (port A) of the on-chip RAM. It accepts one byte, halfword or word request, then splits it into byte-serial RAM cycles. Read data is assembled big-endian and zero-extended, and the requester gets a single-cycle `ack`. Port B (instruction fetch) does not pass through this block.

## Interface
- `ADDRESS_WIDTH`, 32, width of CPU and RAM addresses.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `addr`  in  ADDRESS_WIDTH  byte address of the most significant byte.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`  out  32  load result, zero-extended; valid while `ack`=1.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from request acceptance until the `ack` cycle inclusive.
- `err`  out  1  one-cycle misalignment pulse (only with ALIGN_CHECK_EN).
- `ram_addr`  out  ADDRESS_WIDTH  RAM port-A address.
- `ram_din`  out  8  RAM write byte.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  8  RAM port-A read byte.
- `ram_busy`  in  1  RAM port-A busy; read byte is invalid while high.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, WRITE, DONE.
- Byte count N: 1, 2 or 4 from `size`. Byte index k counts 0..N-1. RAM address for byte k is `base+k`, with modulo 2^ADDRESS_WIDTH wrap.
- IDLE, `req`=1:
  - Latch `addr`, `we`, N and `wdata`.
  - Clear the assembly register and set k=0.
  - Go to WRITE if `we`=1, otherwise ISSUE.
- ISSUE: drive `ram_addr`=base+k with `ram_we`=0, then go to CAPTURE.
- CAPTURE:
  - Keep driving the same `ram_addr`.
  - If `ram_busy`=0: shift `ram_dout` into the assembly register (`asm <= {asm[23:0], ram_dout}`) and increment k. Go to DONE if k was N-1, otherwise ISSUE.
  - If `ram_busy`=1: stay in CAPTURE.
- WRITE:
  - Drive `ram_addr`=base+k, `ram_we`=1, and `ram_din`=byte (N-1-k) of the right-aligned `wdata` (big-endian: MS byte first).
  - Increment k. Go to DONE after k=N-1.
  - `ram_busy` is ignored during writes.
- DONE: `ack`=1 and `rdata`=assembly register (0 for stores), then go to IDLE.
- `req` is ignored outside IDLE. A new request may be accepted the cycle after DONE.
- `reset` in any state: go to IDLE and drop any in-flight access; bytes already written stay written. Outputs after reset:
  - `rdata`, `ack`, `busy`, `err`, `ram_we`, `ram_din` = 0.
  - `ram_addr` = 0.
- `ram_we` is 0 in every state except WRITE.

## Timing
- The `req` sampling edge is cycle 0.
- Load latency (no RAM busy): byte `ack` in cycle 3, half in cycle 5, word in cycle 9. Each `ram_busy` cycle in CAPTURE adds one cycle.
- Store latency: byte `ack` in cycle 2, half in cycle 3, word in cycle 5.
- The RAM read byte is expected one cycle after its address is driven (the CAPTURE cycle).
- `busy` is registered and rises the cycle after acceptance; it falls the cycle after `ack`.

## Configuration
- `ALIGN_CHECK_EN` defined:
  - In IDLE, a halfword with `addr[0]`=1 or a word with `addr[1:0]`≠0 performs no RAM access.
  - The block pulses `err`=1 and `ack`=1 together in cycle 1 with `rdata`=0, then returns to IDLE.
- Not defined: `err` is tied to 0 and misaligned accesses proceed byte-serially from `addr`.

## Test plan
- Preload RAM[0x10..0x13]=12 34 56 78; word load from 0x10 -> `ack` in cycle 9, `rdata`=0x12345678, `ram_we` never 1.
- Word store of 0xDEADBEEF to 0x20 -> RAM writes 0x20=DE, 0x21=AD, 0x22=BE, 0x23=EF on consecutive cycles, `ack` in cycle 5. A subsequent byte load from 0x22 returns 0x000000BE.
- Halfword load from 0x11 with `ram_busy` held high for 3 cycles during the first CAPTURE -> `rdata`=0x00003456, `ack` in cycle 8.
- `reset` asserted in cycle 2 of a word store to 0x40 -> only 0x40 and 0x41 are written; all outputs read 0 in the next cycle; a new `req` is accepted immediately after.
- Word load from 0xFFFFFFFE -> addresses wrap (FFFFFFFE, FFFFFFFF, 0, 1).
- With ALIGN_CHECK_EN: word load from 0x13 -> `err`=`ack`=1 in cycle 1, `rdata`=0, no RAM access.
